// File: rtl/range_ctrl.sv
// Key-driven sequencer for the Collatz range engine: debounce, launch, busy lockout, browse offset.
// Optional hold-to-repeat stepping is enabled by defining RANGE_CTRL_AUTO_REPEAT_EN.
`timescale 1ns/1ps

module range_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 4194304,
  parameter int unsigned RAM_WORDS       = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  input  logic        done,
  output logic        go,
  output logic [31:0] start,
  output logic [7:0]  offset,
  output logic [11:0] n,
  output logic        busy
);

  // state  | meaning
  // IDLE   | keys accepted, offset browsable
  // LAUNCH | go asserted for one cycle
  // RUN    | engine running, waiting for done
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  localparam int unsigned      DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       OFF_MAX = 8'(RAM_WORDS - 1);

  state_t          state;
  logic [3:0]      key_meta, key_s;
  logic [9:0]      sw_meta, sw_s;
  logic [3:0]      key_db, key_db_q;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      press;
  logic            held_up, held_dn, held_both;
  logic            rpt_up, rpt_dn;
  logic            step_up, step_dn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_s    <= '1;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db   <= '1;
      key_db_q <= '1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      key_db_q <= key_db;
      for (int i = 0; i < 4; i++) begin
        if (key_s[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_db[i] <= key_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = key_db_q & ~key_db;
  assign held_up   = ~key_db[0];
  assign held_dn   = ~key_db[1];
  assign held_both = held_up & held_dn;

`ifdef RANGE_CTRL_AUTO_REPEAT_EN
  localparam int unsigned      RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_arm;
  logic             rpt_fire;

  assign rpt_fire = rpt_arm && (rpt_cnt == RPT_LAST);
  assign rpt_up   = rpt_fire & held_up;
  assign rpt_dn   = rpt_fire & held_dn;

  // Repeat only arms on a press event seen in IDLE, so a key held across busy stays inert.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
      rpt_arm <= 1'b0;
    end else if (state != IDLE || held_both || !(held_up || held_dn)) begin
      rpt_cnt <= '0;
      rpt_arm <= 1'b0;
    end else if (press[0] || press[1]) begin
      rpt_cnt <= '0;
      rpt_arm <= 1'b1;
    end else if (rpt_arm) begin
      rpt_cnt <= rpt_fire ? '0 : rpt_cnt + 1'b1;
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = (REPEAT_CYCLES != 0);
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  assign step_up = (press[0] | rpt_up) & ~held_both;
  assign step_dn = (press[1] | rpt_dn) & ~held_both;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      go     <= 1'b0;
      busy   <= 1'b0;
      start  <= '0;
      offset <= '0;
    end else begin
      go <= 1'b0;
      case (state)
        IDLE: begin
          if (press[3]) begin
            state  <= LAUNCH;
            go     <= 1'b1;
            busy   <= 1'b1;
            start  <= {22'b0, sw_s};
            offset <= '0;
          end else if (press[2]) begin
            offset <= '0;
          end else if (step_up) begin
            if (offset != OFF_MAX) offset <= offset + 1'b1;
          end else if (step_dn) begin
            if (offset != 8'd0) offset <= offset - 1'b1;
          end
        end
        LAUNCH: state <= RUN;
        RUN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= '0;
    else          n <= {2'b0, sw_s} + {4'b0, offset};
  end

endmodule

// File: tb/tb_range_ctrl.sv
// Bench for range_ctrl: table of offset-step vectors plus launch/busy/reset sequences.
// Launch start values are checked through a scoreboard queue popped on every go pulse.
`timescale 1ns/1ps

module tb_range_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic        done;
  logic        go;
  logic [31:0] start;
  logic [7:0]  offset;
  logic [11:0] n;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  logic go_q = 1'b0;
  longint exp_q[$];

  typedef struct {
    logic [3:0] kn;
    int         hold;
    logic [7:0] exp_off;
    string      name;
  } vec_t;

  vec_t vtab[8];

`ifdef RANGE_CTRL_AUTO_REPEAT_EN
  localparam logic [7:0] EXP_RPT = 8'd4;
`else
  localparam logic [7:0] EXP_RPT = 8'd1;
`endif

  range_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8),
    .RAM_WORDS      (256)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_n),
    .sw     (sw),
    .done   (done),
    .go     (go),
    .start  (start),
    .offset (offset),
    .n      (n),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] kn, input int hold);
    key_n = kn;
    cyc(hold);
    key_n = 4'hF;
    cyc(14);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy == lvl) break;
    end
    chk(name, busy, lvl);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  // Scoreboard: each go pulse must match a queued launch and last one cycle.
  always @(negedge clk) begin
    if (reset_n && go) begin
      go_cnt <= go_cnt + 1;
      chk("go_width", go_q, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL go_unexpected: got go with start %0d, no launch queued at %0t", start, $time);
      end else begin
        chk("start", start, exp_q.pop_front());
        chk("busy_at_go", busy, 1);
      end
    end
    go_q <= go;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int gc0;

    vtab[0] = '{4'b1101, 6, 8'd0, "dec_sat0"};
    vtab[1] = '{4'b1110, 6, 8'd1, "inc1"};
    vtab[2] = '{4'b1110, 6, 8'd2, "inc2"};
    vtab[3] = '{4'b1101, 6, 8'd1, "dec1"};
    vtab[4] = '{4'b1100, 6, 8'd1, "inc_dec_both"};
    vtab[5] = '{4'b1010, 6, 8'd0, "clr_over_inc"};
    vtab[6] = '{4'b1110, 6, 8'd1, "inc3"};
    vtab[7] = '{4'b1011, 6, 8'd0, "clr"};

    reset_n = 1'b0;
    key_n   = 4'hF;
    sw      = 10'd5;
    done    = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_go", go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_offset", offset, 0);
    chk("rst_n", n, 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("n_after_reset", n, 5);

    sw = 10'd100;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      press(vtab[i].kn, vtab[i].hold);
      @(negedge clk);
      chk(vtab[i].name, offset, vtab[i].exp_off);
      chk({vtab[i].name, "_n"}, n, 100 + vtab[i].exp_off);
    end

    for (int i = 0; i < 256; i++) press(4'b1110, 6);
    @(negedge clk);
    chk("sat_255", offset, 255);
    chk("sat_255_n", n, 355);
    press(4'b1101, 6);
    @(negedge clk);
    chk("dec_from_255", offset, 254);
    press(4'b1011, 6);

    key_n = 4'b1110;
    cyc(30);
    key_n = 4'hF;
    cyc(14);
    @(negedge clk);
    chk("hold_repeat", offset, EXP_RPT);

    sw = 10'd27;
    cyc(4);
    exp_q.push_back(27);
    gc0 = go_cnt;
    key_n = 4'b0111;
    cyc(15);
    @(negedge clk);
    chk("launch_busy", busy, 1);
    chk("launch_start", start, 27);
    chk("launch_clr_off", offset, 0);
    cyc(1);
    pulse_done();
    @(negedge clk);
    chk("done_busy_low", busy, 0);
    cyc(6);
    key_n = 4'hF;
    cyc(20);
    chk("launch_go_count", go_cnt - gc0, 1);

    gc0 = go_cnt;
    key_n = 4'b0111;
    cyc(2);
    key_n = 4'hF;
    cyc(20);
    @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_go_count", go_cnt - gc0, 0);

    exp_q.push_back(27);
    key_n = 4'b0111;
    cyc(10);
    key_n = 4'hF;
    wait_busy(1'b1, "busy_launch2");
    cyc(1);
    key_n = 4'b1110;
    cyc(12);
    pulse_done();
    cyc(12);
    key_n = 4'hF;
    cyc(14);
    @(negedge clk);
    chk("busy_step_ignored", offset, 0);
    chk("busy_step_idle", busy, 0);

    exp_q.push_back(27);
    key_n = 4'b0111;
    cyc(8);
    key_n = 4'hF;
    wait_busy(1'b1, "busy_launch3");
    cyc(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_go", go, 0);
    chk("midrun_rst_start", start, 0);
    chk("midrun_rst_n", n, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    pulse_done();
    cyc(3);
    @(negedge clk);
    chk("done_after_rst", busy, 0);

    sw = 10'd9;
    cyc(4);
    exp_q.push_back(9);
    gc0 = go_cnt;
    key_n = 4'b0111;
    cyc(8);
    key_n = 4'hF;
    wait_busy(1'b1, "busy_relaunch");
    cyc(3);
    pulse_done();
    wait_busy(1'b0, "idle_relaunch");
    cyc(10);
    chk("relaunch_go_count", go_cnt - gc0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_ctrl.md
# range_ctrl

Key-driven sequencer for the Collatz `range` engine on the lab board. It does four things:
- debounces the four active-low pushbuttons;
- launches the engine with a single-cycle `go` and the switch value as `start`;
- blocks user input while the engine runs;
- maintains a saturating browse offset, with optional hold-to-repeat, used to step through the 256 stored results.

It sits between the raw board I/O and `range`, replacing ad-hoc key logic in the top level.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronized key must differ from its debounced level before that level flips.
- `REPEAT_CYCLES`, 4194304: hold period between auto-repeat steps (about 12 Hz at 50 MHz).
- `RAM_WORDS`, 256: result count; offset saturates at `RAM_WORDS-1`.
- `clk`, in, 1: 50 MHz system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `key_n`, in, 4: raw pushbuttons, low = pressed.
  - [0] increment offset; [1] decrement offset; [2] clear offset; [3] launch.
- `sw`, in, 10: raw switches, the base value.
- `done`, in, 1: completion pulse from `range`.
- `go`, out, 1: single-cycle launch pulse to `range`.
- `start`, out, 32: start value to `range`, equal to `{22'b0, sw_s}`.
- `offset`, out, 8: browse offset.
- `n`, out, 12: displayed value, `{2'b0, sw_s} + offset`.
- `busy`, out, 1: engine running; keys ignored while high.

## Operation
- **Synchronizers:** `key_n` and `sw` each pass through a 2-FF synchronizer. `sw_s` is the synchronized switch value.
- **Debounce:** one counter per key.
  - Counter clears whenever the synchronized key equals its debounced level.
  - Otherwise it increments; when it reaches `DEBOUNCE_CYCLES-1`, the debounced level flips and the counter clears.
  - A press event is a debounced 1→0 transition, lasting one cycle.
- **FSM states:**
  - IDLE → LAUNCH on a key[3] press event. In the same edge, `start` is loaded from `sw_s` and `offset` is cleared.
  - LAUNCH → RUN unconditionally. `go` = 1 only while in LAUNCH.
  - RUN → IDLE when `done` = 1. `done` is ignored in IDLE and LAUNCH.
  - `busy` = 1 in LAUNCH and RUN.
- **Offset** (IDLE only). Priority: key[3] launch > key[2] clear > key[0]/key[1] step.
  - key[0] step: `offset + 1`, saturating at `RAM_WORDS-1`.
  - key[1] step: `offset - 1`, saturating at 0.
  - key[0] and key[1] both debounced-pressed: no step, and the repeat counter is held at 0.
  - key[2] press event: `offset` = 0.
- **Display value:** `n` is registered every cycle as `{2'b0, sw_s} + offset`, 12-bit, with no overflow possible (max 1023 + 255).
- **Key presses while `busy`:** ignored. Events are not queued. A key still held when `busy` falls does not generate a new event.
- **Reset:** `reset_n` low forces IDLE immediately, whether idle or mid-run.
  - `go` = 0, `busy` = 0, `start` = 0, `offset` = 0, `n` = 0.
  - Debounced levels = 1 (released); all counters = 0.

## Timing
- A press event in cycle T produces `go` = 1 in cycle T+1 for exactly one cycle; `busy` = 1 from T+1.
- `done` high in cycle D (in RUN) gives `busy` = 0 from D+1. A key[3] event is accepted from D+1.
- A step event at T updates `offset` at T+1 and `n` at T+2.
- Raw key to debounced event: 2 synchronizer cycles plus `DEBOUNCE_CYCLES`.

## Configuration
- **`RANGE_CTRL_AUTO_REPEAT_EN` defined:**
  - While exactly one of key[0]/key[1] stays debounced-pressed in IDLE, a repeat counter counts cycles after the press event.
  - Each time it reaches `REPEAT_CYCLES`, one further step is applied and the counter clears.
  - Releasing the key clears the counter.
- **Not defined:** exactly one step per press event; no repeat counter is synthesized.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8.
- **Reset values:** assert `reset_n`=0 → `go`, `busy`, `start`, `offset` and `n` are all 0. Release with `sw`=5 → `n`=5 within 4 cycles.
- **Launch and completion:** `sw`=27, hold key[3] low for 20 cycles → exactly one `go` pulse, `start`=27, `busy`=1. Pulse `done` → `busy`=0 next cycle; key[3] still held gives no second `go`.
- **Glitch rejection:** key[3] low for 2 cycles → no `go`, `busy` stays 0.
- **Hold-to-repeat:** key[0] held for 30 cycles after the debounced press → `offset`=4 with `RANGE_CTRL_AUTO_REPEAT_EN` (steps at press, +8, +16, +24); `offset`=1 without it.
- **Saturation and priority:**
  - `offset`=255 plus a key[0] press → stays 255.
  - `offset`=0 plus a key[1] press → stays 0.
  - key[0] and key[1] pressed together → no change.
  - key[2] pressed together with key[0] → `offset`=0.
  - Steps attempted while `busy` → `offset` unchanged.
- **Reset mid-run:** `reset_n`=0 in RUN → `busy`=0 and state IDLE immediately. A later `done` pulse changes nothing; the next key[3] press launches normally.
